// File: rtl/frame_buffer_swap.sv
// -----------------------------------------------------------------------------
// frame_buffer_swap
//
// Double-buffered frame store sitting after the ray transformation stage.
// The 320x180 RGB565 render stream is written into the back bank. The
// 1280x720 display is served from the front bank with a 4x nearest-neighbour
// upscale. Banks swap at the first display frame start that follows a
// completely written render frame.
//
// Ports
//   pixel_clk_in       single clock for the write and read sides
//   rst_n_in           asynchronous active-low reset (released synchronously)
//   ray_valid_in       ray_address_in / ray_pixel_in / ray_last_pixel_in valid
//   ray_address_in     render-space address, hcount + vcount*SCREEN_WIDTH
//   ray_pixel_in       RGB565 pixel
//   ray_last_pixel_in  final pixel of the render frame
//   hcount_in          display x
//   vcount_in          display y
//   active_draw_in     display active region
//   new_frame_in       one-cycle pulse at display frame start (in blanking)
//   render_hold_out    back bank full and swap pending; upstream must stall
//   front_bank_out     bank currently displayed
//   frame_count_out    completed swaps, wraps 255->0
//   overflow_out       sticky: a write was dropped
//   pixel_out          RGB565 to the display, 0 outside the active region
//   pixel_valid_out    active_draw_in delayed by 2 cycles
//   dbg_state_out      FSM state: 0 = FILL, 1 = WAIT_SWAP
//
// Write handshake: ray_valid_in is the valid and !render_hold_out is the
// ready. A beat is taken on every edge where ray_valid_in is high; a beat
// presented while render_hold_out is high, or with an address outside the
// bank, is dropped and recorded in overflow_out instead of being stalled.
// -----------------------------------------------------------------------------
module frame_buffer_swap #(
    parameter int FULL_SCREEN_WIDTH  = 1280,
    parameter int FULL_SCREEN_HEIGHT = 720,
    parameter int SCREEN_WIDTH       = 320,
    parameter int SCREEN_HEIGHT      = 180,
    parameter int FB_DEPTH           = 57600
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        ray_valid_in,
    input  logic [15:0] ray_address_in,
    input  logic [15:0] ray_pixel_in,
    input  logic        ray_last_pixel_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        active_draw_in,
    input  logic        new_frame_in,
    output logic        render_hold_out,
    output logic        front_bank_out,
    output logic [7:0]  frame_count_out,
    output logic        overflow_out,
    output logic [15:0] pixel_out,
    output logic        pixel_valid_out,
    output logic        dbg_state_out
);

    localparam logic [15:0] FB_DEPTH_W = 16'(FB_DEPTH);

    typedef enum logic {
        S_FILL      = 1'b0,
        S_WAIT_SWAP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion reaches every register immediately,
    // release is aligned to the clock two edges later.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    logic       r_front_bank;
    logic       r_render_hold;
    logic [7:0] r_frame_count;
    logic       r_overflow;
    logic       w_addr_ok;
    logic       w_wr_en;

    assign w_addr_ok = (ray_address_in < FB_DEPTH_W);
    assign w_wr_en   = (r_state == S_FILL) && ray_valid_in && w_addr_ok;

    always_ff @(posedge pixel_clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= S_FILL;
            r_front_bank  <= 1'b0;
            r_render_hold <= 1'b0;
            r_frame_count <= 8'd0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    // new_frame_in is ignored here, including on the edge
                    // that takes the last pixel: the swap waits a frame.
                    if (ray_valid_in) begin
                        if (w_addr_ok) begin
                            if (ray_last_pixel_in) begin
                                r_state       <= S_WAIT_SWAP;
                                r_render_hold <= 1'b1;
                            end
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                S_WAIT_SWAP: begin
                    if (ray_valid_in) begin
                        r_overflow <= 1'b1;
                    end
                    if (new_frame_in) begin
                        r_front_bank  <= ~r_front_bank;
                        r_frame_count <= r_frame_count + 8'd1;
                        r_render_hold <= 1'b0;
                        r_state       <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read address: (vcount/4)*320 + hcount/4, with *320 done as
    // *256 + *64. Kept to 16 bits; out-of-bank results read as zero.
    // ------------------------------------------------------------------
    logic [15:0] w_row;
    logic [15:0] w_col;
    logic [15:0] w_rd_addr;

    assign w_row     = {8'd0, vcount_in[9:2]};
    assign w_col     = {7'd0, hcount_in[10:2]};
    assign w_rd_addr = (w_row << 8) + (w_row << 6) + w_col;

    // Stage 1: address, bank and active flag. The bank is latched here so
    // a swap only affects reads issued after it.
    logic [15:0] r_rd_addr;
    logic        r_rd_bank;
    logic        r_act1;
    logic        r_act2;

    always_ff @(posedge pixel_clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_addr <= 16'd0;
            r_rd_bank <= 1'b0;
            r_act1    <= 1'b0;
            r_act2    <= 1'b0;
        end else begin
            r_rd_addr <= w_rd_addr;
            r_rd_bank <= r_front_bank;
            r_act1    <= active_draw_in;
            r_act2    <= r_act1;
        end
    end

    // ------------------------------------------------------------------
    // Bank storage (contents not reset). Writes always go to the back
    // bank and reads to the latched front bank, so the two never meet.
    // Stage 2 is the registered RAM output.
    // ------------------------------------------------------------------
    logic [15:0] r_bank0 [0:FB_DEPTH-1];
    logic [15:0] r_bank1 [0:FB_DEPTH-1];
    logic [15:0] r_rd_data;

    always_ff @(posedge pixel_clk_in) begin
        if (w_wr_en && r_front_bank) begin
            r_bank0[ray_address_in] <= ray_pixel_in;
        end
        if (w_wr_en && !r_front_bank) begin
            r_bank1[ray_address_in] <= ray_pixel_in;
        end
        if (r_rd_addr < FB_DEPTH_W) begin
            r_rd_data <= r_rd_bank ? r_bank1[r_rd_addr] : r_bank0[r_rd_addr];
        end else begin
            r_rd_data <= 16'h0000;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign render_hold_out = r_render_hold;
    assign front_bank_out  = r_front_bank;
    assign frame_count_out = r_frame_count;
    assign overflow_out    = r_overflow;
    assign pixel_valid_out = r_act2;
    assign pixel_out       = r_act2 ? r_rd_data : 16'h0000;
    assign dbg_state_out   = (r_state == S_WAIT_SWAP);

endmodule

// File: tb/tb_frame_buffer_swap.sv
module tb_frame_buffer_swap;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        ray_valid = 1'b0;
  logic [15:0] ray_addr = 16'd0;
  logic [15:0] ray_px = 16'd0;
  logic        ray_last = 1'b0;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd0;
  logic        active = 1'b0;
  logic        new_frame = 1'b0;
  logic        render_hold;
  logic        front_bank;
  logic [7:0]  frame_count;
  logic        overflow;
  logic [15:0] pixel_out;
  logic        pixel_valid;
  logic        dbg_state;

  frame_buffer_swap dut (
    .pixel_clk_in      (clk),
    .rst_n_in          (rst_n),
    .ray_valid_in      (ray_valid),
    .ray_address_in    (ray_addr),
    .ray_pixel_in      (ray_px),
    .ray_last_pixel_in (ray_last),
    .hcount_in         (hcount),
    .vcount_in         (vcount),
    .active_draw_in    (active),
    .new_frame_in      (new_frame),
    .render_hold_out   (render_hold),
    .front_bank_out    (front_bank),
    .frame_count_out   (frame_count),
    .overflow_out      (overflow),
    .pixel_out         (pixel_out),
    .pixel_valid_out   (pixel_valid),
    .dbg_state_out     (dbg_state)
  );

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        act_d1 = 1'b0;
  logic        act_d2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected pixel_valid timing: active_draw delayed by two clocks
  always @(posedge clk) begin
    act_d1 <= active;
    act_d2 <= act_d1;
  end

  // monitor: pops an expected pixel whenever the display output is valid
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pixel_valid_lag", {31'd0, pixel_valid}, {31'd0, act_d2});
      if (pixel_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_unexpected got %0h expected none at %0t", pixel_out, $time);
        end else begin
          chk("pixel_out", {16'd0, pixel_out}, {16'd0, exp_q.pop_front()});
        end
      end else begin
        chk("pixel_blank", {16'd0, pixel_out}, 32'd0);
      end
    end
  end

  // driver tasks (all called at posedge + 1)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] p, input logic l);
    ray_valid = 1'b1;
    ray_addr  = a;
    ray_px    = p;
    ray_last  = l;
    tick();
    ray_valid = 1'b0;
    ray_last  = 1'b0;
  endtask

  task automatic nf();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  task automatic disp(input logic [10:0] h, input logic [9:0] v, input logic a, input logic [15:0] e);
    hcount = h;
    vcount = v;
    active = a;
    if (a) exp_q.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) disp(11'd1300, 10'd750, 1'b0, 16'd0);
  endtask

  task automatic ctrl(input string tag, input logic st, input logic fb, input logic [7:0] fc,
                      input logic hold, input logic ovf);
    chk({tag, "_state"}, {31'd0, dbg_state}, {31'd0, st});
    chk({tag, "_front"}, {31'd0, front_bank}, {31'd0, fb});
    chk({tag, "_count"}, {24'd0, frame_count}, {24'd0, fc});
    chk({tag, "_hold"}, {31'd0, render_hold}, {31'd0, hold});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf});
  endtask

  task automatic do_reset();
    idle(4);
    chk("queue_drain", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    mon_en = 1'b1;
  endtask

  initial begin
    tick();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    mon_en = 1'b1;

    // reset state
    ctrl("reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("reset_pixel", {16'd0, pixel_out}, 32'd0);
    chk("reset_pvalid", {31'd0, pixel_valid}, 32'd0);

    // full frame into bank 1, pixel = address
    for (int i = 0; i < 57600; i++) begin
      ray_valid = 1'b1;
      ray_addr  = i[15:0];
      ray_px    = i[15:0];
      ray_last  = (i == 57599);
      tick();
    end
    ray_valid = 1'b0;
    ray_last  = 1'b0;
    ctrl("full_wait", 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    nf();
    ctrl("full_swap", 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
    disp(11'd8, 10'd4, 1'b1, 16'd322);
    idle(4);

    // display sweep of the first four lines: each render pixel four times
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 1280; h++) begin
        disp(h[10:0], v[9:0], 1'b1, {7'd0, h[10:2]});
      end
      idle(16);
    end

    // out-of-range write in FILL
    wr(16'd57600, 16'h5555, 1'b0);
    ctrl("oob_write", 1'b0, 1'b1, 8'd1, 1'b0, 1'b1);

    do_reset();
    ctrl("reset2", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // new_frame in FILL has no effect
    nf();
    ctrl("nf_in_fill", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // short frame into bank 1, then a discarded write while holding
    for (int i = 0; i < 10; i++) wr(16'hA000 + i[15:0] - 16'hA000, 16'hA000 + i[15:0], (i == 9));
    ctrl("short_wait", 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    wr(16'd5, 16'hFFFF, 1'b0);
    ctrl("hold_drop", 1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
    nf();
    ctrl("short_swap", 1'b0, 1'b1, 8'd1, 1'b0, 1'b1);
    disp(11'd20, 10'd0, 1'b1, 16'hA005);   // addr 5 not overwritten
    disp(11'd8, 10'd4, 1'b1, 16'd322);     // older data kept over reset
    disp(11'd40, 10'd0, 1'b1, 16'd10);
    disp(11'd36, 10'd0, 1'b1, 16'hA009);
    idle(4);

    do_reset();

    // last pixel and new_frame on the same edge: no swap yet
    for (int i = 0; i < 4; i++) begin
      new_frame = (i == 3);
      wr(i[15:0], 16'hC000 + i[15:0], (i == 3));
    end
    new_frame = 1'b0;
    ctrl("simul_noswap", 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    nf();
    ctrl("simul_swap", 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
    disp(11'd8, 10'd0, 1'b1, 16'hC002);
    idle(4);

    // frame counter wrap
    for (int k = 0; k < 255; k++) begin
      wr(16'd0, 16'h0777, 1'b1);
      nf();
      if (k == 253) chk("count_255", {24'd0, frame_count}, 32'd255);
    end
    ctrl("count_wrap", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // asynchronous reset while filling, with live outputs
    wr(16'd57600, 16'd0, 1'b0);
    disp(11'd0, 10'd0, 1'b1, 16'h0777);
    disp(11'd1, 10'd0, 1'b1, 16'h0777);
    disp(11'd2, 10'd0, 1'b1, 16'h0777);
    chk("pre_rst_pixel", {16'd0, pixel_out}, 32'h0777);
    chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    mon_en = 1'b0;
    exp_q.delete();
    ray_valid = 1'b1;
    ray_addr  = 16'd100;
    ray_px    = 16'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    ctrl("async_rst", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("async_rst_pixel", {16'd0, pixel_out}, 32'd0);
    chk("async_rst_pvalid", {31'd0, pixel_valid}, 32'd0);
    ray_valid = 1'b0;
    active    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
